// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave_if
//  Purpose  : AXI3-subset bus bundle (AR/R/AW/W/B channels) between a master
//             and the axi_sram_slave responder.
//  Ports    : none; all channel signals are interface members.
//             master modport drives AR/AW/W valid/payload and R/B ready,
//             slave modport drives AR/AW/W ready and R/B valid/payload.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_sram_slave_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Purpose  : AXI3-subset slave backed by a 2^ADDR_WIDTH x 32-bit SRAM.
//             Independent read and write FSMs, one outstanding transaction
//             each; FIXED/INCR/WRAP bursts; IDs echoed on R and B.
//  Ports    : clk   - clock
//             reset - asynchronous active-high reset
//             bus   - axi_sram_slave_if.slave (AR, R, AW, W, B channels)
//  Revision : 1.0  initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic        clk,
    input  wire logic        reset,
    axi_sram_slave_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address of the following beat; reserved burst type behaves as FIXED.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] incr;
        logic [31:0] mask;
        incr = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) * incr) - 32'd1;
        case (burst)
            2'b01:   return addr + incr;
            2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
            default: return addr;
        endcase
    endfunction

    function automatic logic burst_err(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (burst == 2'b11) || (size > 3'd2) || bad_wrap;
    endfunction

    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [0:0]            rd_state_q;
    logic [3:0]            rd_id_q;
    logic [31:0]           rd_addr_q;
    logic [31:0]           rd_addr_d;
    logic [7:0]            rd_len_q;
    logic [2:0]            rd_size_q;
    logic [1:0]            rd_burst_q;
    logic [7:0]            rd_beat_q;
    logic [1:0]            rd_resp_q;
    logic [31:0]           rd_data_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rd_last;
    logic                  rd_fetch;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign ar_hs     = bus.arvalid && (rd_state_q == R_IDLE);
    assign r_hs      = bus.rready && (rd_state_q == R_DATA);
    assign rd_last   = (rd_beat_q == rd_len_q);
    assign rd_addr_d = next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
    // Fetch the first word at AR acceptance and each following word as the
    // current beat is consumed, so rdata is already registered when rvalid is.
    assign rd_fetch  = ar_hs || (r_hs && !rd_last);
    assign rd_idx    = ar_hs ? bus.araddr[ADDR_WIDTH+1:2] : rd_addr_d[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_beat_q  <= '0;
            rd_resp_q  <= RESP_OKAY;
            rd_data_q  <= '0;
        end else begin
            if (rd_state_q == R_IDLE) begin
                if (ar_hs) begin
                    rd_id_q    <= bus.arid;
                    rd_addr_q  <= bus.araddr;
                    rd_len_q   <= bus.arlen;
                    rd_size_q  <= bus.arsize;
                    rd_burst_q <= bus.arburst;
                    rd_beat_q  <= '0;
                    rd_resp_q  <= burst_err(bus.arlen, bus.arsize, bus.arburst)
                                  ? RESP_SLVERR : RESP_OKAY;
                    rd_state_q <= R_DATA;
                end
            end else if (r_hs) begin
                if (rd_last) begin
                    rd_state_q <= R_IDLE;
                end else begin
                    rd_addr_q <= rd_addr_d;
                    rd_beat_q <= rd_beat_q + 8'd1;
                end
            end
            // Non-blocking read of mem_q: a same-edge write is seen next time.
            if (rd_fetch) begin
                rd_data_q <= mem_q[rd_idx];
            end
        end
    end

    assign bus.arready = (rd_state_q == R_IDLE);
    assign bus.rvalid  = (rd_state_q == R_DATA);
    assign bus.rlast   = (rd_state_q == R_DATA) && rd_last;
    assign bus.rid     = rd_id_q;
    assign bus.rdata   = rd_data_q;
    assign bus.rresp   = rd_resp_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]            wr_state_q;
    logic [3:0]            wr_id_q;
    logic [31:0]           wr_addr_q;
    logic [31:0]           wr_addr_d;
    logic [7:0]            wr_len_q;
    logic [2:0]            wr_size_q;
    logic [1:0]            wr_burst_q;
    logic [7:0]            wr_beat_q;
    logic                  wr_err_q;   // illegal burst: suppress memory writes
    logic                  wr_lerr_q;  // wlast seen before the final beat
    logic [3:0]            wr_bid_q;
    logic [1:0]            wr_bresp_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_idx;

    assign aw_hs     = bus.awvalid && (wr_state_q == W_IDLE);
    assign w_hs      = bus.wvalid && (wr_state_q == W_DATA);
    assign wr_last   = (wr_beat_q == wr_len_q);
    assign wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
    assign mem_we    = w_hs && !wr_err_q;
    assign wr_idx    = wr_addr_q[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= 1'b0;
            wr_lerr_q  <= 1'b0;
            wr_bid_q   <= '0;
            wr_bresp_q <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_id_q    <= bus.awid;
                        wr_addr_q  <= bus.awaddr;
                        wr_len_q   <= bus.awlen;
                        wr_size_q  <= bus.awsize;
                        wr_burst_q <= bus.awburst;
                        wr_beat_q  <= '0;
                        wr_err_q   <= burst_err(bus.awlen, bus.awsize, bus.awburst);
                        wr_lerr_q  <= 1'b0;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wr_last) begin
                            // Beat count ends the burst; a missing wlast here
                            // or an earlier premature one reports SLVERR.
                            wr_bid_q   <= wr_id_q;
                            wr_bresp_q <= (wr_err_q || wr_lerr_q || !bus.wlast)
                                          ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_addr_q <= wr_addr_d;
                            wr_beat_q <= wr_beat_q + 8'd1;
                            if (bus.wlast) begin
                                wr_lerr_q <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // SRAM array has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.awready = (wr_state_q == W_IDLE);
    assign bus.wready  = (wr_state_q == W_DATA);
    assign bus.bvalid  = (wr_state_q == W_RESP);
    assign bus.bid     = wr_bid_q;
    assign bus.bresp   = wr_bresp_q;

    // wid carries no meaning for this slave.
    logic w_unused;
    assign w_unused = ^bus.wid;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_slave
//  Purpose  : Self-checking bench for axi_sram_slave with a word-array
//             reference memory and burst address model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_sram_slave;

    logic clk = 1'b0;
    logic reset;

    axi_sram_slave_if bus();

    axi_sram_slave #(.ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model [4096];

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_count;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic        wr_last [16];
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_held;
    int          b_ok;

    // ---------------------------------------------------------------- model
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int n);
        longint unsigned incr, total, base, aa;
        incr  = 64'd1 << size;
        total = (longint'(len) + 1) * incr;
        aa    = longint'(a);
        case (burst)
            2'b01:   return 32'(aa + longint'(n) * incr);
            2'b10: begin
                base = aa - (aa % total);
                return 32'(base + ((aa - base + longint'(n) * incr) % total));
            end
            default: return a;
        endcase
    endfunction

    function automatic bit spec_err(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
        int beats;
        beats = int'(len) + 1;
        return (burst == 2'b11) || (size > 3'd2) ||
               (burst == 2'b10 && !(beats inside {2, 4, 8, 16}));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        int i;
        if (!spec_err(len, size, burst)) begin
            for (int n = 0; n <= int'(len); n++) begin
                i = widx(beat_addr(a, len, size, burst, n));
                for (int b = 0; b < 4; b++)
                    if (wr_strb[n][b]) model[i][8*b +: 8] = wr_data[n][8*b +: 8];
            end
        end
    endtask

    // ------------------------------------------------------- bus drivers
    // All drivers start and end at a falling edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int budget = 100;
        bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        while (!bus.arready && budget > 0) begin @(negedge clk); budget--; end
        if (budget == 0) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: arready got 0 required 1");
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit rnd);
        int budget = 400;
        do_ar(id, a, len, size, burst);
        rd_count = 0;
        while (rd_count <= int'(len) && budget > 0) begin
            bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rvalid && bus.rready) begin
                rd_data[rd_count] = bus.rdata;
                rd_resp[rd_count] = bus.rresp;
                rd_last[rd_count] = bus.rlast;
                rd_count++;
            end
            @(negedge clk);
            budget--;
        end
        bus.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int hold);
        int budget;
        budget = 100;
        bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        while (!bus.awready && budget > 0) begin @(negedge clk); budget--; end
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int n = 0; n <= int'(len); n++) begin
            bus.wdata = wr_data[n]; bus.wstrb = wr_strb[n]; bus.wlast = wr_last[n];
            bus.wid = id; bus.wvalid = 1'b1;
            while (!bus.wready && budget > 0) begin @(negedge clk); budget--; end
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b0;
        while (!bus.bvalid && budget > 0) begin @(negedge clk); budget--; end
        b_ok = (budget > 0);
        b_id = bus.bid; b_resp = bus.bresp;
        repeat (hold) @(negedge clk);
        b_held = bus.bvalid;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        model_write(a, len, size, burst);
    endtask

    task automatic fill_incr(input int beats, input logic [31:0] base_val, input bit rnd);
        for (int n = 0; n < 16; n++) begin
            wr_data[n] = rnd ? $urandom : base_val + 32'(n);
            wr_strb[n] = 4'hF;
            wr_last[n] = (n == beats - 1);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast, bus.bvalid} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 110000",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast, bus.bvalid});
        end
        vectors++;
        if ({bus.rid, bus.bid, bus.rresp, bus.bresp} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_ids: got %h required 000", {bus.rid, bus.bid, bus.rresp, bus.bresp});
        end
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h required 00000000", bus.rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        fill_incr(1, 32'hDEADBEEF, 0);
        axi_write(4'h0, 32'h40, 8'd0, 3'd2, 2'b01, 0);
        bus.arid = 4'h1; bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1;
        vectors++;
        if (bus.arready !== 1'b1) begin
            miscompares++; $display("FAIL single_arready: got %b required 1", bus.arready);
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        vectors++;
        if ({bus.rvalid, bus.rlast, bus.rresp, bus.rid, bus.rdata} !== {1'b1, 1'b1, 2'b00, 4'h1, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL single_beat: got v=%b l=%b resp=%b id=%h data=%h required v=1 l=1 resp=00 id=1 data=deadbeef",
                     bus.rvalid, bus.rlast, bus.rresp, bus.rid, bus.rdata);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        vectors++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_done: got rvalid=%b arready=%b required 0/1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_wrap_read;
        logic [31:0] exp [4];
        logic [31:0] pdata, edata;
        logic        plast, stall;
        int          cnt, budget;
        exp = '{32'd2, 32'd3, 32'd0, 32'd1};
        fill_incr(4, 32'd0, 0);
        axi_write(4'h2, 32'h100, 8'd3, 3'd2, 2'b01, 0);
        axi_read(4'h2, 32'h108, 8'd3, 3'd2, 2'b10, 0);
        vectors++;
        if (rd_count != 4) begin
            miscompares++; $display("FAIL wrap_count: got %0d required 4", rd_count);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({rd_data[k], rd_last[k], rd_resp[k]} !== {exp[k], (k == 3), 2'b00}) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: got data=%h last=%b resp=%b required data=%h last=%b resp=00",
                         k, rd_data[k], rd_last[k], rd_resp[k], exp[k], (k == 3));
            end
        end
        // Same burst with a randomly toggling rready; held beats must not move.
        do_ar(4'h3, 32'h108, 8'd3, 3'd2, 2'b10);
        cnt = 0; budget = 200; stall = 1'b0; pdata = '0; plast = 1'b0;
        while (cnt < 4 && budget > 0) begin
            if (stall) begin
                vectors++;
                if ({bus.rdata, bus.rlast} !== {pdata, plast}) begin
                    miscompares++;
                    $display("FAIL wrap_stall: got %h/%b required %h/%b", bus.rdata, bus.rlast, pdata, plast);
                end
            end
            bus.rready = 1'($urandom_range(0, 1));
            if (bus.rvalid && bus.rready) begin
                edata = model[widx(beat_addr(32'h108, 8'd3, 3'd2, 2'b10, cnt))];
                vectors++;
                if (bus.rdata !== edata) begin
                    miscompares++;
                    $display("FAIL wrap_rand_beat%0d: got %h required %h", cnt, bus.rdata, edata);
                end
                cnt++;
            end
            stall = bus.rvalid && !bus.rready;
            pdata = bus.rdata; plast = bus.rlast;
            @(negedge clk);
            budget--;
        end
        bus.rready = 1'b0;
        vectors++;
        if (cnt != 4) begin
            miscompares++; $display("FAIL wrap_rand_count: got %0d required 4", cnt);
        end
    endtask

    task automatic test_strobe_write;
        logic [31:0] pre [4];
        logic [31:0] exp [4];
        fill_incr(4, 32'd0, 1);
        for (int n = 0; n < 4; n++) pre[n] = wr_data[n];
        axi_write(4'h4, 32'h200, 8'd3, 3'd2, 2'b01, 0);
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        wr_data[2] = 32'h33333333; wr_data[3] = 32'h44444444;
        wr_data[1] = 32'h33333333; // strobe 3 writes low half 0x3333
        wr_data[2] = 32'h55555555; // strobe 0 writes nothing
        wr_strb[0] = 4'hF; wr_strb[1] = 4'h3; wr_strb[2] = 4'h0; wr_strb[3] = 4'hC;
        axi_write(4'h5, 32'h200, 8'd3, 3'd2, 2'b01, 0);
        vectors++;
        if ({b_ok[0], b_id, b_resp} !== {1'b1, 4'h5, 2'b00}) begin
            miscompares++;
            $display("FAIL strobe_bresp: got ok=%0d id=%h resp=%b required ok=1 id=5 resp=00", b_ok, b_id, b_resp);
        end
        exp[0] = 32'h11111111;
        exp[1] = {pre[1][31:16], 16'h3333};
        exp[2] = pre[2];
        exp[3] = {16'h4444, pre[3][15:0]};
        axi_read(4'h6, 32'h200, 8'd3, 3'd2, 2'b01, 1);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_data[k] !== exp[k] || rd_data[k] !== model[widx(32'h200 + 32'(4*k))]) begin
                miscompares++;
                $display("FAIL strobe_read%0d: got %h required %h", k, rd_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_early_wlast;
        fill_incr(2, 32'd0, 1);
        wr_last[0] = 1'b1; wr_last[1] = 1'b0;
        axi_write(4'h7, 32'h300, 8'd1, 3'd2, 2'b01, 5);
        vectors++;
        if ({b_ok[0], b_held, b_id, b_resp} !== {1'b1, 1'b1, 4'h7, 2'b10}) begin
            miscompares++;
            $display("FAIL early_wlast_b: got ok=%0d held=%b id=%h resp=%b required 1/1/7/10",
                     b_ok, b_held, b_id, b_resp);
        end
        axi_read(4'h7, 32'h300, 8'd1, 3'd2, 2'b01, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (rd_data[k] !== model[widx(32'h300 + 32'(4*k))]) begin
                miscompares++;
                $display("FAIL early_wlast_data%0d: got %h required %h", k, rd_data[k],
                         model[widx(32'h300 + 32'(4*k))]);
            end
        end
    endtask

    task automatic test_concurrent_error;
        logic [31:0] old [8];
        fill_incr(8, 32'd0, 1);
        fork
            axi_read(4'h8, 32'h100, 8'd3, 3'd2, 2'b01, 1);
            axi_write(4'h9, 32'h500, 8'd7, 3'd2, 2'b01, 0);
        join
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_data[k] !== model[widx(32'h100 + 32'(4*k))] || rd_resp[k] !== 2'b00) begin
                miscompares++;
                $display("FAIL conc_read%0d: got %h/%b required %h/00", k, rd_data[k], rd_resp[k],
                         model[widx(32'h100 + 32'(4*k))]);
            end
        end
        vectors++;
        if ({b_ok[0], b_id, b_resp} !== {1'b1, 4'h9, 2'b00}) begin
            miscompares++; $display("FAIL conc_bresp: got id=%h resp=%b required 9/00", b_id, b_resp);
        end
        // Reserved burst type: every beat SLVERR, full beat count.
        axi_read(4'hA, 32'h500, 8'd2, 3'd2, 2'b11, 0);
        vectors++;
        if (rd_count != 3) begin
            miscompares++; $display("FAIL err_read_count: got %0d required 3", rd_count);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rd_resp[k], rd_last[k]} !== {2'b10, (k == 2)}) begin
                miscompares++;
                $display("FAIL err_read_beat%0d: got resp=%b last=%b required 10/%b", k, rd_resp[k], rd_last[k], (k == 2));
            end
        end
        // WRAP with 3 beats is illegal: SLVERR and memory untouched.
        for (int k = 0; k < 8; k++) old[k] = model[widx(32'h500 + 32'(4*k))];
        fill_incr(3, 32'd0, 1);
        axi_write(4'hB, 32'h500, 8'd2, 3'd2, 2'b10, 0);
        vectors++;
        if (b_resp !== 2'b10) begin
            miscompares++; $display("FAIL err_write_bresp: got %b required 10", b_resp);
        end
        axi_read(4'hB, 32'h500, 8'd7, 3'd2, 2'b01, 0);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (rd_data[k] !== old[k]) begin
                miscompares++; $display("FAIL err_write_mem%0d: got %h required %h", k, rd_data[k], old[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, e;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          lens [4];
        lens = '{1, 3, 7, 15};
        for (int it = 0; it < 8; it++) begin
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 2));
            len   = (burst == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 7));
            // Random upper bits exercise address aliasing.
            a     = ({$urandom} << 14) | (32'h0800 + 32'($urandom_range(0, 1023)));
            for (int n = 0; n < 16; n++) begin
                wr_data[n] = $urandom; wr_strb[n] = 4'($urandom); wr_last[n] = (n == int'(len));
            end
            axi_write(4'($urandom), a, len, size, burst, 0);
            vectors++;
            if (b_resp !== 2'b00) begin
                miscompares++; $display("FAIL rand%0d_bresp: got %b required 00", it, b_resp);
            end
            axi_read(4'hC, a ^ 32'h8000_0000, len, size, burst, 1);
            for (int k = 0; k <= int'(len); k++) begin
                e = model[widx(beat_addr(a, len, size, burst, k))];
                vectors++;
                if (rd_data[k] !== e || rd_last[k] !== (k == int'(len))) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b required %h/%b", it, k, rd_data[k], rd_last[k], e, (k == int'(len)));
                end
            end
        end
    endtask

    task automatic test_reset_midburst;
        do_ar(4'hD, 32'h100, 8'd3, 3'd2, 2'b01);
        bus.rready = 1'b1;
        @(negedge clk);           // first beat consumed, second beat presented
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.rvalid, bus.arready, bus.rlast} !== 3'b010) begin
            miscompares++;
            $display("FAIL midburst_reset: got rvalid=%b arready=%b rlast=%b required 0/1/0",
                     bus.rvalid, bus.arready, bus.rlast);
        end
        bus.rready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        axi_read(4'hE, 32'h200, 8'd3, 3'd2, 2'b01, 0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_data[k] !== model[widx(32'h200 + 32'(4*k))] || rd_count != 4) begin
                miscompares++;
                $display("FAIL post_reset_read%0d: got %h required %h", k, rd_data[k], model[widx(32'h200 + 32'(4*k))]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_single_read();
        test_wrap_read();
        test_strobe_write();
        test_early_wlast();
        test_concurrent_error();
        test_random();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
